// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with 4-entry byte FIFO
module mmio_uart_tx #(
    parameter int unsigned DEFAULT_DIV = 868,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        tx
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [29:0] W_TX   = BASE_ADDR[31:2];
    localparam logic [29:0] W_STAT = W_TX + 30'd1;
    localparam logic [29:0] W_DIV  = W_TX + 30'd2;

    state_t      state, state_d;
    logic [7:0]  fifo [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        ovf;
    logic [15:0] div, cnt, cnt_d;
    logic [7:0]  shreg, shreg_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic        pop, push, tx_d;
    logic        hit_tx, hit_stat, hit_div, wr_tx, full, empty, busy;

    logic unused_bits;
    assign unused_bits = &{1'b0, dataadr[1:0], writedata[31:16]};

    assign hit_tx   = (dataadr[31:2] == W_TX);
    assign hit_stat = (dataadr[31:2] == W_STAT);
    assign hit_div  = (dataadr[31:2] == W_DIV);
    assign sel      = hit_tx | hit_stat | hit_div;

    assign full  = (count == 3'd4);
    assign empty = (count == 3'd0);
    assign busy  = (state != IDLE);

    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign wr_tx = memwrite & hit_tx;
    assign push  = wr_tx & (~full | pop);

    always_comb begin
        rdata = 32'b0;
        if (hit_stat)
            rdata = {28'b0, ovf, busy, empty, full};
        else if (hit_div)
            rdata = {16'b0, div};
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        shreg_d   = shreg;
        bit_idx_d = bit_idx;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shreg_d   = fifo[rd_ptr];
                    cnt_d     = div - 16'd1;
                    bit_idx_d = 3'd0;
                    state_d   = START;
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    state_d = DATA;
                    cnt_d   = div - 16'd1;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    cnt_d = div - 16'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shreg_d   = shreg >> 1;
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == 16'd0) begin
                    // Chain straight into the next frame when data is waiting.
                    if (!empty) begin
                        pop       = 1'b1;
                        shreg_d   = fifo[rd_ptr];
                        cnt_d     = div - 16'd1;
                        bit_idx_d = 3'd0;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
            count   <= 3'd0;
            ovf     <= 1'b0;
            div     <= 16'(DEFAULT_DIV);
            cnt     <= 16'd0;
            shreg   <= 8'd0;
            bit_idx <= 3'd0;
        end else begin
            state   <= state_d;
            tx      <= tx_d;
            cnt     <= cnt_d;
            shreg   <= shreg_d;
            bit_idx <= bit_idx_d;
            if (push)
                wr_ptr <= wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, push} - {2'b0, pop};
            if (wr_tx && !push)
                ovf <= 1'b1;
            else if (memwrite && hit_stat)
                ovf <= 1'b0;
            if (memwrite && hit_div)
                div <= (writedata[15:0] == 16'd0) ? 16'd1 : writedata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= writedata[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - randomized and directed bench for mmio_uart_tx against a queue-based line model
module tb_mmio_uart_tx;
    localparam int          DEF_DIV = 868;
    localparam logic [31:0] BASE    = 32'h0000_0400;
    localparam logic [31:0] A_TX    = BASE;
    localparam logic [31:0] A_STAT  = BASE + 32'd4;
    localparam logic [31:0] A_DIV   = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dataadr = 32'b0;
    logic [31:0] writedata = 32'b0;
    logic        memwrite = 1'b0;
    logic [31:0] rdata;
    logic        sel;
    logic        tx;

    mmio_uart_tx #(.DEFAULT_DIV(DEF_DIV), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .dataadr(dataadr), .writedata(writedata),
        .memwrite(memwrite), .rdata(rdata), .sel(sel), .tx(tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: pending bytes, plus the line level for the current and every future cycle.
    byte unsigned m_q[$];
    bit           m_line[$];
    int           m_div = DEF_DIV;
    bit           m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {28'b0, m_ovf, (m_line.size() != 0), (m_q.size() == 0), (m_q.size() == 4)};
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd12);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        if (!in_window(a)) return 32'b0;
        case ((a - BASE) >> 2)
            1:       return exp_status();
            2:       return 32'(m_div);
            default: return 32'b0;
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
        byte unsigned b;
        if (r) begin
            m_q.delete();
            m_line.delete();
            m_div = DEF_DIV;
            m_ovf = 1'b0;
            return;
        end
        if (m_line.size() > 0) void'(m_line.pop_front());
        if (m_line.size() == 0 && m_q.size() > 0) begin
            b = m_q.pop_front();
            repeat (m_div) m_line.push_back(1'b0);
            for (int i = 0; i < 8; i++) repeat (m_div) m_line.push_back(b[i]);
            repeat (m_div) m_line.push_back(1'b1);
        end
        if (!we || !in_window(a)) return;
        case ((a - BASE) >> 2)
            0: if (m_q.size() < 4) m_q.push_back(d[7:0]); else m_ovf = 1'b1;
            1: m_ovf = 1'b0;
            default: m_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
        endcase
    endtask

    task automatic cycle(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit r;
        memwrite  = we;
        dataadr   = a;
        writedata = d;
        r = rst;
        @(posedge clk);
        model_edge(r, we, a, d);
        #1;
        memwrite = 1'b0;
        dataadr  = A_STAT;
        #1;
        check("tx", {31'b0, tx}, {31'b0, (m_line.size() != 0) ? m_line[0] : 1'b1});
        check("status", rdata, exp_status());
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, A_STAT, 32'b0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cycle(1'b1, a, d);
    endtask

    task automatic read_check(input string tag, input logic [31:0] a);
        dataadr = a;
        #1;
        check(tag, rdata, exp_rdata(a));
        check({tag, "_sel"}, {31'b0, sel}, {31'b0, in_window(a)});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0]  pat;
        logic [31:0] a;
        int          op;

        do_reset();
        check("rst_tx", {31'b0, tx}, 32'd1);
        read_check("rst_status", A_STAT);
        dataadr = A_STAT; #1;
        check("rst_status_const", rdata, 32'h0000_0002);
        read_check("rst_div", A_DIV);

        // Single 0x55 frame at div=4 with an explicit waveform.
        store(A_DIV, 32'd4);
        store(A_TX, 32'h55);
        pat = 8'h55;
        for (int j = 1; j <= 41; j++) begin
            idle(1);
            if (j <= 4)       check("f55_start", {31'b0, tx}, 32'd0);
            else if (j <= 36) check("f55_data", {31'b0, tx}, {31'b0, pat[(j - 5) / 4]});
            else if (j <= 40) check("f55_stop", {31'b0, tx}, 32'd1);
            else              check("f55_busy_end", {31'b0, rdata[2]}, 32'd0);
        end

        // Back-to-back stores at div=2: fill, overflow, gap-free frames.
        store(A_DIV, 32'd2);
        idle(1);
        for (int i = 1; i <= 5; i++) store(A_TX, 32'(i));
        check("burst_full", {31'b0, rdata[0]}, 32'd1);
        store(A_TX, 32'h06);
        check("burst_ovf", {31'b0, rdata[3]}, 32'd1);
        idle(110);
        store(A_STAT, 32'b0);
        check("ovf_clear", {31'b0, rdata[3]}, 32'd0);

        // Divisor 0 saturates to 1; frame lasts 10 cycles.
        store(A_DIV, 32'd0);
        read_check("div_zero", A_DIV);
        store(A_TX, 32'hA5);
        idle(10);
        check("div1_busy10", {31'b0, rdata[2]}, 32'd1);
        idle(1);
        check("div1_done11", {31'b0, rdata[2]}, 32'd0);

        // Reset in the middle of the data bits.
        store(A_DIV, 32'd3);
        store(A_TX, 32'h3C);
        store(A_TX, 32'hC3);
        idle(12);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_tx", {31'b0, tx}, 32'd1);
        check("midrst_status", rdata, 32'h0000_0002);
        read_check("midrst_div", A_DIV);

        // Stores outside the window have no effect.
        store(A_DIV, 32'd2);
        store(BASE + 32'd12, 32'h77);
        store(32'h0000_0000, 32'h78);
        store(32'h0000_1000, 32'h79);
        read_check("oow_12", BASE + 32'd12);
        read_check("oow_0", 32'h0000_0000);
        read_check("oow_1000", 32'h0000_1000);
        read_check("div_byte_addr", BASE + 32'd11);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            op = int'($urandom_range(0, 11));
            if (op <= 3) begin
                store(A_TX + 32'($urandom_range(0, 3)), $urandom);
            end else if (op == 4) begin
                store(A_STAT, $urandom);
            end else if (op == 5 && m_line.size() == 0 && m_q.size() == 0) begin
                store(A_DIV, {$urandom_range(0, 65535), 16'($urandom_range(0, 4))});
            end else if (op == 6) begin
                a = $urandom;
                if (in_window(a)) a = BASE + 32'd12;
                store(a, $urandom);
            end else if (op == 7) begin
                read_check("rand_read", BASE - 32'd4 + 32'($urandom_range(0, 19)));
                idle(1);
            end else begin
                idle(1);
            end
        end
        idle(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
